pr_slot_scheduler: RTL

Sequences partial-reconfiguration (PR) requests for the RCA grid. It consumes `{ou_id, grid_slot}` requests drained from the PR request queue and skips requests whose target slot already holds the requested OU. For each remaining request it quiesces the target slot, hands it to the PR/ICAP controller, and tracks completion. It owns the per-slot loaded-OU table, and its per-slot `slot_busy` output is the RCA issue stall.

---
 rtl/pr_slot_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pr_slot_scheduler.sv
// pr_slot_scheduler: sequences PR requests per RCA slot, dedups loaded OUs, stalls the target slot during reload.
// Optional WAIT timeout built when PR_SCHED_TIMEOUT_EN is defined.
module pr_slot_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_W         = 2,
  parameter int OU_ID_W        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [OU_ID_W-1:0]           req_ou_id,
  input  logic [SLOT_W-1:0]            req_slot,
  input  logic [NUM_SLOTS-1:0]         slot_inflight,
  output logic                         pr_start,
  input  logic                         pr_ready,
  output logic [OU_ID_W-1:0]           pr_ou_id,
  output logic [SLOT_W-1:0]            pr_slot,
  input  logic                         pr_done,
  input  logic                         pr_error,
  output logic [NUM_SLOTS-1:0]         slot_busy,
  output logic [NUM_SLOTS-1:0]         slot_valid,
  output logic [NUM_SLOTS*OU_ID_W-1:0] slot_ou_id,
  output logic                         err_sticky,
  input  logic                         err_clr
);
  typedef enum logic [2:0] {IDLE, DRAIN, START, WAIT, UPDATE} state_t;
  state_t                       state_q, state_d;
  logic [OU_ID_W-1:0]           cur_ou_q, cur_ou_d;
  logic [SLOT_W-1:0]            cur_slot_q, cur_slot_d;
  logic                         err_q, err_d;
  logic                         pr_start_q, pr_start_d;
  logic [OU_ID_W-1:0]           pr_ou_q, pr_ou_d;
  logic [SLOT_W-1:0]            pr_slot_q, pr_slot_d;
  logic [NUM_SLOTS-1:0]         slot_busy_q, slot_busy_d;
  logic [NUM_SLOTS-1:0]         slot_valid_q, slot_valid_d;
  logic [NUM_SLOTS*OU_ID_W-1:0] slot_ou_q, slot_ou_d;
  logic                         err_sticky_q, err_sticky_d;
  logic                         dup;
  logic                         timeout;
  assign dup = slot_valid_q[req_slot] && (slot_ou_q[req_slot*OU_ID_W +: OU_ID_W] == req_ou_id);
`ifdef PR_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // WAIT-cycle counter; any other state holds it at zero so it restarts on each WAIT entry
  always_comb cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  // counter register
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
  assign timeout = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif
  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_ou_q     <= '0;
      cur_slot_q   <= '0;
      err_q        <= 1'b0;
      pr_start_q   <= 1'b0;
      pr_ou_q      <= '0;
      pr_slot_q    <= '0;
      slot_busy_q  <= '0;
      slot_valid_q <= '0;
      slot_ou_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_ou_q     <= cur_ou_d;
      cur_slot_q   <= cur_slot_d;
      err_q        <= err_d;
      pr_start_q   <= pr_start_d;
      pr_ou_q      <= pr_ou_d;
      pr_slot_q    <= pr_slot_d;
      slot_busy_q  <= slot_busy_d;
      slot_valid_q <= slot_valid_d;
      slot_ou_q    <= slot_ou_d;
      err_sticky_q <= err_sticky_d;
    end
  end
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (req_valid && !dup) ? DRAIN : IDLE;
      DRAIN:   state_d = slot_inflight[cur_slot_q] ? DRAIN : START;
      START:   state_d = pr_ready ? WAIT : START;
      WAIT:    state_d = (pr_done || timeout) ? UPDATE : WAIT;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // registered outputs and slot table updates per state
  always_comb begin
    cur_ou_d     = cur_ou_q;
    cur_slot_d   = cur_slot_q;
    err_d        = err_q;
    pr_start_d   = pr_start_q;
    pr_ou_d      = pr_ou_q;
    pr_slot_d    = pr_slot_q;
    slot_busy_d  = slot_busy_q;
    slot_valid_d = slot_valid_q;
    slot_ou_d    = slot_ou_q;
    case (state_q)
      IDLE: if (req_valid) begin
        cur_ou_d   = req_ou_id;
        cur_slot_d = req_slot;
        if (!dup) begin
          slot_busy_d            = NUM_SLOTS'(1) << req_slot;
          slot_valid_d[req_slot] = 1'b0;
        end
      end
      DRAIN: if (!slot_inflight[cur_slot_q]) begin
        pr_start_d = 1'b1;
        pr_ou_d    = cur_ou_q;
        pr_slot_d  = cur_slot_q;
      end
      START: pr_start_d = pr_ready ? 1'b0 : 1'b1;
      WAIT: if (pr_done || timeout) err_d = pr_done ? pr_error : 1'b1;
      UPDATE: begin
        slot_busy_d = '0;
        if (!err_q) begin
          slot_valid_d[cur_slot_q]                  = 1'b1;
          slot_ou_d[cur_slot_q*OU_ID_W +: OU_ID_W] = cur_ou_q;
        end
      end
      default: ;
    endcase
    err_sticky_d = ((state_q == UPDATE) && err_q) || (err_sticky_q && !err_clr);
  end
  assign req_ready  = rst && (state_q == IDLE);
  assign pr_start   = pr_start_q;
  assign pr_ou_id   = pr_ou_q;
  assign pr_slot    = pr_slot_q;
  assign slot_busy  = slot_busy_q;
  assign slot_valid = slot_valid_q;
  assign slot_ou_id = slot_ou_q;
  assign err_sticky = err_sticky_q;
endmodule
